dds_sweep_ctrl: RTL and testbench

Sequencer for the DDS generator. It produces the frequency word and phase word that drive the DDS phase accumulator, stepping the frequency linearly from a start value to a stop value. Each frequency is held for a programmable dwell time. Three sweep modes are supported: single, repeating sawtooth and continuous triangle. The block sits between the register/control logic and the DDS core, and its `Fre_word`/`Pha_word` outputs connect directly to the DDS inputs of the same names.

---
 rtl/dds_sweep_ctrl_if.sv | 28 ++
 rtl/dds_sweep_ctrl.sv | 132 +++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/dds_sweep_ctrl_if.sv
// dds_sweep_ctrl_if: control inputs and DDS word outputs of the sweep sequencer
interface dds_sweep_ctrl_if #(
   parameter int PHASE_WIDTH = 32,
   parameter int DWELL_WIDTH = 16
);
   logic                   start;
   logic                   abort;
   logic [1:0]             mode;
   logic [PHASE_WIDTH-1:0] f_start;
   logic [PHASE_WIDTH-1:0] f_stop;
   logic [PHASE_WIDTH-1:0] f_step;
   logic [DWELL_WIDTH-1:0] dwell;
   logic [PHASE_WIDTH-1:0] pha_in;
   logic [PHASE_WIDTH-1:0] Fre_word;
   logic [PHASE_WIDTH-1:0] Pha_word;
   logic                   busy;
   logic                   done;
   logic                   step_stb;
   logic                   dir_down;
   modport master (
      output start, abort, mode, f_start, f_stop, f_step, dwell, pha_in,
      input  Fre_word, Pha_word, busy, done, step_stb, dir_down
   );
   modport slave (
      input  start, abort, mode, f_start, f_stop, f_step, dwell, pha_in,
      output Fre_word, Pha_word, busy, done, step_stb, dir_down
   );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: linear frequency sweep sequencer (single, sawtooth, triangle) for the DDS core
module dds_sweep_ctrl #(
   parameter int PHASE_WIDTH = 32,
   parameter int DWELL_WIDTH = 16
) (
   input  logic             clk_in,
   input  logic             rst_n,
   dds_sweep_ctrl_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;
   state_t                 state, state_n;
   logic [PHASE_WIDTH-1:0] fre, fre_n, pha, pha_n;
   logic [PHASE_WIDTH-1:0] fs, fe, fst;
   logic [DWELL_WIDTH-1:0] cnt, cnt_n, dw, dwell_eff;
   logic [1:0]             mode_r;
   logic                   degen;
   logic                   busy, busy_n, done, done_n, stb, stb_n, dir, dir_n;
   logic                   launch, expire;
   logic [PHASE_WIDTH:0]   sum, diff;
   logic [PHASE_WIDTH-1:0] up_val, dn_val;

   assign launch    = state == IDLE && bus.start && !bus.abort;
   assign dwell_eff = bus.dwell == '0 ? DWELL_WIDTH'(1) : bus.dwell;
   assign expire    = cnt == DWELL_WIDTH'(1);
   // the extra top bit catches overflow/borrow so the clamp never wraps
   assign sum       = {1'b0, fre} + {1'b0, fst};
   assign diff      = {1'b0, fre} - {1'b0, fst};
   assign up_val    = sum > {1'b0, fe} ? fe : sum[PHASE_WIDTH-1:0];
   assign dn_val    = (diff[PHASE_WIDTH] || diff[PHASE_WIDTH-1:0] < fs) ? fs : diff[PHASE_WIDTH-1:0];

   assign bus.Fre_word = fre;
   assign bus.Pha_word = pha;
   assign bus.busy     = busy;
   assign bus.done     = done;
   assign bus.step_stb = stb;
   assign bus.dir_down = dir;

   // sweep parameters are captured once per start so later input changes are ignored
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         mode_r <= '0;
         fs     <= '0;
         fe     <= '0;
         fst    <= '0;
         dw     <= '0;
         degen  <= 1'b0;
      end else if (launch) begin
         mode_r <= bus.mode;
         fs     <= bus.f_start;
         fe     <= bus.f_stop;
         fst    <= bus.f_step;
         dw     <= dwell_eff;
         degen  <= bus.f_step == '0 || bus.f_start >= bus.f_stop;
      end
   end

   // state and all outputs are registered
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         fre   <= '0;
         pha   <= '0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         stb   <= 1'b0;
         dir   <= 1'b0;
      end else begin
         state <= state_n;
         fre   <= fre_n;
         pha   <= pha_n;
         cnt   <= cnt_n;
         busy  <= busy_n;
         done  <= done_n;
         stb   <= stb_n;
         dir   <= dir_n;
      end
   end

   // next state: launch from IDLE, dwell countdown, step/clamp/turn on expiry, abort wins
   always_comb begin
      state_n = state;
      fre_n   = fre;
      pha_n   = pha;
      cnt_n   = cnt;
      busy_n  = busy;
      done_n  = 1'b0;
      stb_n   = 1'b0;
      dir_n   = dir;
      case (state)
         IDLE: if (launch) begin
            state_n = UP;
            fre_n   = bus.f_start;
            pha_n   = bus.pha_in;
            cnt_n   = dwell_eff;
            busy_n  = 1'b1;
            stb_n   = 1'b1;
            dir_n   = 1'b0;
         end
         default: if (bus.abort) begin
            state_n = IDLE;
            cnt_n   = '0;
            busy_n  = 1'b0;
            dir_n   = 1'b0;
         end else if (!expire) begin
            cnt_n = cnt - DWELL_WIDTH'(1);
         end else begin
            cnt_n = dw;
            stb_n = 1'b1;
            if (state == DOWN) begin
               state_n = fre == fs ? UP : DOWN;
               dir_n   = fre != fs;
               fre_n   = fre == fs ? up_val : dn_val;
            end else if (degen || (fre == fe && mode_r != 2'd1 && mode_r != 2'd2)) begin
               state_n = IDLE;
               cnt_n   = '0;
               busy_n  = 1'b0;
               done_n  = 1'b1;
               stb_n   = 1'b0;
            end else if (fre == fe && mode_r == 2'd1) begin
               fre_n = fs;
            end else if (fre == fe) begin
               state_n = DOWN;
               dir_n   = 1'b1;
               fre_n   = dn_val;
            end else begin
               fre_n = up_val;
            end
         end
      endcase
   end
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb_dds_sweep_ctrl: directed checks of the DDS sweep sequencer
module tb_dds_sweep_ctrl;
   logic clk_in = 1'b0;
   logic rst_n  = 1'b0;
   int   total  = 0;
   int   bad    = 0;
   logic [31:0] exp_q[$];
   logic        dir_q[$];

   dds_sweep_ctrl_if #(.PHASE_WIDTH(32), .DWELL_WIDTH(16)) bus ();

   dds_sweep_ctrl #(.PHASE_WIDTH(32), .DWELL_WIDTH(16)) dut (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .bus    (bus)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic check_zero(input string tag);
      check({tag, " fre"}, 64'(bus.Fre_word), 64'd0);
      check({tag, " pha"}, 64'(bus.Pha_word), 64'd0);
      check({tag, " busy"}, 64'(bus.busy), 64'd0);
      check({tag, " done"}, 64'(bus.done), 64'd0);
      check({tag, " stb"}, 64'(bus.step_stb), 64'd0);
      check({tag, " dir"}, 64'(bus.dir_down), 64'd0);
   endtask

   task automatic do_start(input logic [1:0] m, input logic [31:0] fs, input logic [31:0] fe,
                           input logic [31:0] st, input logic [15:0] dw, input logic [31:0] ph);
      bus.mode = m; bus.f_start = fs; bus.f_stop = fe; bus.f_step = st;
      bus.dwell = dw; bus.pha_in = ph; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   // one value per cycle: every listed cycle carries a fresh word and a strobe
   task automatic check_seq(input string tag);
      for (int i = 0; i < exp_q.size(); i++) begin
         check($sformatf("%s fre[%0d]", tag, i), 64'(bus.Fre_word), 64'(exp_q[i]));
         check($sformatf("%s stb[%0d]", tag, i), 64'(bus.step_stb), 64'd1);
         check($sformatf("%s busy[%0d]", tag, i), 64'(bus.busy), 64'd1);
         check($sformatf("%s done[%0d]", tag, i), 64'(bus.done), 64'd0);
         if (dir_q.size() > i)
            check($sformatf("%s dir[%0d]", tag, i), 64'(bus.dir_down), 64'(dir_q[i]));
         tick();
      end
   endtask

   task automatic stop_sweep();
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      check("stop busy", 64'(bus.busy), 64'd0);
   endtask

   initial begin
      bus.start = 1'b0; bus.abort = 1'b0; bus.mode = '0; bus.f_start = '0;
      bus.f_stop = '0; bus.f_step = '0; bus.dwell = '0; bus.pha_in = '0;
      #1;
      check_zero("reset");
      #12 rst_n = 1'b1;
      tick();
      check_zero("idle after reset");

      // mode 0 exact hit, dwell 3; inputs scrambled after start must not matter
      do_start(2'd0, 32'd100, 32'd130, 32'd10, 16'd3, 32'd5);
      bus.f_stop = 32'd0; bus.f_step = 32'd1; bus.f_start = 32'd7; bus.pha_in = 32'd9;
      check("m0 pha", 64'(bus.Pha_word), 64'd5);
      for (int c = 1; c <= 14; c++) begin
         check($sformatf("m0 fre c%0d", c), 64'(bus.Fre_word), c <= 12 ? 64'(100 + 10 * ((c - 1) / 3)) : 64'd130);
         check($sformatf("m0 stb c%0d", c), 64'(bus.step_stb), 64'(c <= 12 && (c - 1) % 3 == 0));
         check($sformatf("m0 done c%0d", c), 64'(bus.done), 64'(c == 13));
         check($sformatf("m0 busy c%0d", c), 64'(bus.busy), 64'(c <= 12));
         tick();
      end

      // clamp at a stop value the step does not hit
      do_start(2'd0, 32'd100, 32'd125, 32'd10, 16'd1, 32'd0);
      exp_q = '{32'd100, 32'd110, 32'd120, 32'd125};
      dir_q = {};
      check_seq("clamp");
      check("clamp done", 64'(bus.done), 64'd1);
      check("clamp busy", 64'(bus.busy), 64'd0);
      check("clamp hold", 64'(bus.Fre_word), 64'd125);
      tick();

      // clamp near the top of the range without wrap
      do_start(2'd0, 32'hFFFF_FFEC, 32'hFFFF_FFFF, 32'd16, 16'd1, 32'd0);
      exp_q = '{32'hFFFF_FFEC, 32'hFFFF_FFFC, 32'hFFFF_FFFF};
      check_seq("wrap");
      check("wrap done", 64'(bus.done), 64'd1);
      tick();

      // triangle: turning points held once, dir_down on the down leg, no done
      do_start(2'd2, 32'd100, 32'd130, 32'd10, 16'd1, 32'd0);
      exp_q = '{32'd100, 32'd110, 32'd120, 32'd130, 32'd120, 32'd110, 32'd100, 32'd110, 32'd120};
      dir_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      check_seq("tri");
      stop_sweep();
      dir_q = {};

      // sawtooth with dwell 0 behaving as 1
      do_start(2'd1, 32'd100, 32'd130, 32'd10, 16'd0, 32'd0);
      exp_q = '{32'd100, 32'd110, 32'd120, 32'd130, 32'd100, 32'd110};
      check_seq("saw");
      stop_sweep();
      tick();

      // degenerate: zero step, single point for one dwell then done even in triangle mode
      do_start(2'd2, 32'd100, 32'd130, 32'd0, 16'd2, 32'd0);
      check("deg fre c1", 64'(bus.Fre_word), 64'd100);
      check("deg stb c1", 64'(bus.step_stb), 64'd1);
      tick();
      check("deg fre c2", 64'(bus.Fre_word), 64'd100);
      check("deg stb c2", 64'(bus.step_stb), 64'd0);
      check("deg done c2", 64'(bus.done), 64'd0);
      tick();
      check("deg done c3", 64'(bus.done), 64'd1);
      check("deg busy c3", 64'(bus.busy), 64'd0);
      tick();

      // abort together with start while sweeping
      do_start(2'd0, 32'd100, 32'd130, 32'd10, 16'd3, 32'd0);
      repeat (3) tick();
      check("abt pre fre", 64'(bus.Fre_word), 64'd110);
      bus.abort = 1'b1; bus.start = 1'b1;
      tick();
      bus.abort = 1'b0; bus.start = 1'b0;
      check("abt busy", 64'(bus.busy), 64'd0);
      check("abt fre", 64'(bus.Fre_word), 64'd110);
      check("abt done", 64'(bus.done), 64'd0);
      check("abt stb", 64'(bus.step_stb), 64'd0);
      repeat (4) tick();
      check("abt idle busy", 64'(bus.busy), 64'd0);
      check("abt idle fre", 64'(bus.Fre_word), 64'd110);
      check("abt idle done", 64'(bus.done), 64'd0);

      // reset mid-sweep clears outputs without a clock edge
      do_start(2'd0, 32'd200, 32'd300, 32'd10, 16'd2, 32'd77);
      tick();
      #2 rst_n = 1'b0;
      #1 check_zero("mid reset");
      #3 rst_n = 1'b1;
      tick();
      do_start(2'd0, 32'd100, 32'd130, 32'd10, 16'd1, 32'd3);
      check("rerun fre", 64'(bus.Fre_word), 64'd100);
      check("rerun pha", 64'(bus.Pha_word), 64'd3);
      check("rerun stb", 64'(bus.step_stb), 64'd1);
      check("rerun busy", 64'(bus.busy), 64'd1);
      tick();
      check("rerun fre2", 64'(bus.Fre_word), 64'd110);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
